// File: rtl/wb_pic_dispatcher_pkg.sv
// rtl/wb_pic_dispatcher_pkg.sv - PIC register map and dispatcher state encoding
package wb_pic_pkg;

  localparam logic [7:0] PIC_PEND = 8'h00;
  localparam logic [7:0] PIC_EN   = 8'h04;
  localparam logic [7:0] PIC_PRI  = 8'h08;
  localparam logic [7:0] PIC_GCTL = 8'h0C;
  localparam logic [7:0] PIC_ACK  = 8'h10;
  localparam logic [7:0] PIC_HIGH = 8'h14;

  typedef enum logic [3:0] {
    ST_INIT_EN,
    ST_INIT_PRI,
    ST_INIT_GEN,
    ST_IDLE,
    ST_CLAIM,
    ST_CLEAR,
    ST_PRESENT,
    ST_SERVICE,
    ST_SETTLE
  } state_e;

endpackage

// File: rtl/wb_pic_dispatcher_xfer.sv
// rtl/wb_pic_dispatcher_xfer.sv - single-access Wishbone master with ack timeout
module pic_wb_xfer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout,
  output logic [7:0]  pic_addr,
  output logic [31:0] pic_wdata,
  output logic        pic_we,
  output logic        pic_stb,
  input  logic [31:0] pic_rdata,
  input  logic        pic_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          stb_q, stb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign done      = stb_q & pic_ack;
  assign timeout   = stb_q & ~pic_ack & (cnt_q == CNT_LAST);
  assign rdata     = pic_rdata;
  assign pic_addr  = addr_q;
  assign pic_wdata = wdata_q;
  assign pic_we    = we_q;
  assign pic_stb   = stb_q;

  // start is only honoured between accesses, so callers may hold it high
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    if (!stb_q) begin
      if (start) begin
        addr_d  = addr;
        wdata_d = wdata;
        we_d    = we;
        stb_d   = 1'b1;
        cnt_d   = '0;
      end
    end else if (pic_ack || timeout) begin
      stb_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_pic_dispatcher.sv
// rtl/wb_pic_dispatcher.sv - PIC init, claim/clear and CPU vector handshake sequencer
module wb_pic_dispatcher
  import wb_pic_pkg::*;
#(
  parameter bit          AUTO_INIT = 1'b1,
  parameter logic [7:0]  EN_INIT   = 8'hFF,
  parameter logic [31:0] PRI_INIT  = 32'h76543210,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pic_addr,
  output logic [31:0] pic_wdata,
  output logic        pic_we,
  output logic        pic_stb,
  input  logic [31:0] pic_rdata,
  input  logic        pic_ack,
  input  logic        pic_irq,
  input  logic        dispatch_en,
  output logic        vec_valid,
  output logic [2:0]  vec_id,
  input  logic        vec_ready,
  input  logic        eoi,
  input  logic        err_clr,
  output logic        busy,
  output logic        init_done,
  output logic        bus_err,
  output logic [15:0] dispatch_cnt
);

  localparam state_e RST_STATE = state_e'(AUTO_INIT ? ST_INIT_EN : ST_IDLE);

  state_e      state_q, state_d;
  logic [2:0]  vec_id_q, vec_id_d;
  logic        vec_valid_q, vec_valid_d;
  logic        init_done_q, init_done_d;
  logic        bus_err_q, bus_err_d;
  logic        busy_q, busy_d;
  logic        settle_q, settle_d;
  logic [15:0] dispatch_cnt_q, dispatch_cnt_d;

  logic        x_start, x_we, x_done, x_timeout;
  logic [7:0]  x_addr;
  logic [31:0] x_wdata, x_rdata;
  logic        unused_rdata;

  assign unused_rdata = ^x_rdata[31:3];

  pic_wb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (x_start),
    .addr      (x_addr),
    .we        (x_we),
    .wdata     (x_wdata),
    .done      (x_done),
    .rdata     (x_rdata),
    .timeout   (x_timeout),
    .pic_addr  (pic_addr),
    .pic_wdata (pic_wdata),
    .pic_we    (pic_we),
    .pic_stb   (pic_stb),
    .pic_rdata (pic_rdata),
    .pic_ack   (pic_ack)
  );

  always_comb begin
    state_d        = state_q;
    vec_id_d       = vec_id_q;
    vec_valid_d    = vec_valid_q;
    init_done_d    = init_done_q;
    bus_err_d      = bus_err_q;
    settle_d       = settle_q;
    dispatch_cnt_d = dispatch_cnt_q;
    x_start        = 1'b0;
    x_addr         = PIC_HIGH;
    x_we           = 1'b0;
    x_wdata        = '0;
    if (err_clr) bus_err_d = 1'b0;
    case (state_q)
      ST_INIT_EN: begin
        x_start = 1'b1;
        x_addr  = PIC_EN;
        x_we    = 1'b1;
        x_wdata = {24'h0, EN_INIT};
        if (x_done) state_d = ST_INIT_PRI;
      end
      ST_INIT_PRI: begin
        x_start = 1'b1;
        x_addr  = PIC_PRI;
        x_we    = 1'b1;
        x_wdata = PRI_INIT;
        if (x_done) state_d = ST_INIT_GEN;
      end
      ST_INIT_GEN: begin
        x_start = 1'b1;
        x_addr  = PIC_GCTL;
        x_we    = 1'b1;
        x_wdata = 32'h1;
        if (x_done) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      // The claim read is launched on the IDLE exit edge to save a cycle of latency
      ST_IDLE: begin
        if (pic_irq && dispatch_en && init_done_q) begin
          x_start = 1'b1;
          state_d = ST_CLAIM;
        end
      end
      ST_CLAIM: begin
        x_start = 1'b1;
        if (x_done) begin
          vec_id_d = x_rdata[2:0];
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        x_start = 1'b1;
        x_addr  = PIC_ACK;
        x_we    = 1'b1;
        x_wdata = 32'h1 << vec_id_q;
        if (x_done) begin
          vec_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (vec_ready) begin
          vec_valid_d    = 1'b0;
          dispatch_cnt_d = dispatch_cnt_q + 16'h1;
          settle_d       = 1'b0;
          state_d        = eoi ? ST_SETTLE : ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          settle_d = 1'b0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) state_d = ST_IDLE;
      end
      default: state_d = RST_STATE;
    endcase
    // An init timeout still marks init finished so the sequence is never retried
    if (x_timeout) begin
      state_d   = ST_IDLE;
      bus_err_d = 1'b1;
      if (state_q inside {ST_INIT_EN, ST_INIT_PRI, ST_INIT_GEN}) init_done_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RST_STATE;
      vec_id_q       <= '0;
      vec_valid_q    <= 1'b0;
      init_done_q    <= ~AUTO_INIT;
      bus_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      settle_q       <= 1'b0;
      dispatch_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      vec_id_q       <= vec_id_d;
      vec_valid_q    <= vec_valid_d;
      init_done_q    <= init_done_d;
      bus_err_q      <= bus_err_d;
      busy_q         <= busy_d;
      settle_q       <= settle_d;
      dispatch_cnt_q <= dispatch_cnt_d;
    end
  end

  assign vec_valid    = vec_valid_q;
  assign vec_id       = vec_id_q;
  assign init_done    = init_done_q;
  assign bus_err      = bus_err_q;
  assign busy         = busy_q;
  assign dispatch_cnt = dispatch_cnt_q;

endmodule
